// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
package imem_loader_pkg;

   // Session states of the loader FSM.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int LANE_W         = $clog2(BYTES_PER_WORD);

   // Drop one stream byte into its little-endian lane of a 32-bit word.
   function automatic logic [31:0] lane_insert(input logic [31:0]       word,
                                               input logic [7:0]        data,
                                               input logic [LANE_W-1:0] lane);
      logic [31:0] w;
      w = word;
      w[8*lane +: 8] = data;
      return w;
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Control, byte-stream and memory-write signals of the loader.
interface imem_loader_if;
   logic        start_i;
   logic [15:0] len_i;
   logic        abort_i;
   logic        byte_valid_i;
   logic [7:0]  byte_data_i;
   logic        byte_ready_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic        cpu_run_o;

   // Host / stream source side.
   modport master (
      output start_i, len_i, abort_i, byte_valid_i, byte_data_i,
      input  byte_ready_o, mem_we_o, mem_addr_o, mem_data_o,
             busy_o, done_o, err_o, cpu_run_o
   );

   // Loader side.
   modport slave (
      input  start_i, len_i, abort_i, byte_valid_i, byte_data_i,
      output byte_ready_o, mem_we_o, mem_addr_o, mem_data_o,
             busy_o, done_o, err_o, cpu_run_o
   );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes little-endian into 32-bit words.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear,
   input  logic        byte_accept,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word_next
);

   logic [LANE_W-1:0] lane_q;
   logic [31:0]       word_q;

   // word_next already includes the byte being accepted, so the 4th byte's
   // word is complete in the same cycle word_valid is raised.
   assign word_next  = lane_insert(word_q, byte_data, lane_q);
   assign word_valid = byte_accept && (lane_q == LANE_W'(BYTES_PER_WORD - 1)) && !clear;

   // Lane counter and partial word; clear drops any partial word.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         lane_q <= '0;
         word_q <= '0;
      end else if (clear) begin
         lane_q <= '0;
         word_q <= '0;
      end else if (byte_accept) begin
         lane_q <= lane_q + 1'b1;
         word_q <= word_next;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory and holds the CPU until done.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          WORDS     = 128,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   imem_loader_if.slave bus
);

   localparam int CNT_W = $clog2(WORDS + 1);

   state_t             state_q, state_d;
   logic [15:0]        len_q;
   logic [CNT_W-1:0]   word_cnt_q;
   logic               err_q;
   logic               cpu_run_q;
   logic [31:0]        addr_q;
   logic [31:0]        data_q;

   logic               start_take, start_zero, start_bad, start_load;
   logic               byte_accept, last_word, pk_clear, pk_valid;
   logic [31:0]        pk_word;

   assign start_take  = (state_q == IDLE) && bus.start_i;
   assign start_zero  = start_take && (bus.len_i == 16'd0);
   assign start_bad   = start_take && (bus.len_i > 16'(WORDS));
   assign start_load  = start_take && !start_zero && !start_bad;
   assign byte_accept = bus.byte_valid_i && (state_q == RECV);
   assign last_word   = (16'(word_cnt_q) + 16'd1) == len_q;
   assign pk_clear    = start_load || ((state_q == RECV) && bus.abort_i);

   imem_loader_byte_packer u_packer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear       (pk_clear),
      .byte_accept (byte_accept),
      .byte_data   (bus.byte_data_i),
      .word_valid  (pk_valid),
      .word_next   (pk_word)
   );

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode; abort outranks the DONE transition from WRITE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_zero)      state_d = DONE;
            else if (start_load) state_d = RECV;
         end
         RECV: begin
            if (bus.abort_i)     state_d = IDLE;
            else if (pk_valid)   state_d = WRITE;
         end
         WRITE: begin
            if (bus.abort_i)     state_d = IDLE;
            else if (last_word)  state_d = DONE;
            else                 state_d = RECV;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Session bookkeeping: length, word counter, error and CPU release flags.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         len_q      <= '0;
         word_cnt_q <= '0;
         err_q      <= 1'b0;
         cpu_run_q  <= 1'b0;
      end else begin
         if (start_load) begin
            len_q      <= bus.len_i;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
            cpu_run_q  <= 1'b0;
         end
         if (start_bad) err_q <= 1'b1;
         if ((state_q == RECV) && bus.abort_i) err_q <= 1'b1;
         if (state_q == WRITE) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            if (bus.abort_i) err_q <= 1'b1;
         end
         if (state_q == DONE) cpu_run_q <= 1'b1;
      end
   end

   // Memory port address/data, captured with the completing byte and held.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         addr_q <= '0;
         data_q <= '0;
      end else if ((state_q == RECV) && !bus.abort_i && pk_valid) begin
         addr_q <= BASE_ADDR + (32'(word_cnt_q) << 2);
         data_q <= pk_word;
      end
   end

   assign bus.byte_ready_o = (state_q == RECV);
   assign bus.mem_we_o     = (state_q == WRITE);
   assign bus.busy_o       = (state_q == RECV) || (state_q == WRITE);
   assign bus.done_o       = (state_q == DONE);
   assign bus.mem_addr_o   = addr_q;
   assign bus.mem_data_o   = data_q;
   assign bus.err_o        = err_q;
   assign bus.cpu_run_o    = cpu_run_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of word vectors plus corner sequences.
module tb_imem_loader;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   imem_loader_if bus();

   imem_loader #(.WORDS(128), .BASE_ADDR(32'h0000_0000)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0]  b0, b1, b2, b3;
      int          gap;
      logic [31:0] exp_data;
      logic [31:0] exp_addr;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_acc_cyc = 0;
   int start_cyc    = 0;
   int done_cnt     = 0;
   int done_cyc     = -1;
   int overlap_cnt  = 0;
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          wr_cyc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Record every write and done pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.mem_we_o) begin
            wr_addr_q.push_back(bus.mem_addr_o);
            wr_data_q.push_back(bus.mem_data_o);
            wr_cyc_q.push_back(cyc);
         end
         if (bus.done_o) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
         end
         if (bus.mem_we_o && bus.byte_ready_o) overlap_cnt = overlap_cnt + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] wr_addr(input int i);
      return (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] wr_data(input int i);
      return (i < wr_data_q.size()) ? wr_data_q[i] : 32'hxxxx_xxxx;
   endfunction

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      done_cnt    = 0;
      done_cyc    = -1;
      overlap_cnt = 0;
   endtask

   // Called #1 after a rising edge; returns #1 after a rising edge.
   task automatic start_load(input logic [15:0] len, input logic with_abort);
      bus.start_i = 1'b1;
      bus.abort_i = with_abort;
      bus.len_i   = len;
      @(posedge clk); #1;
      start_cyc   = cyc;
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input int gap);
      int n;
      n = 0;
      bus.byte_valid_i = 1'b1;
      bus.byte_data_i  = d;
      @(negedge clk);
      while (!bus.byte_ready_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.byte_ready_o) begin
         check("byte_accept_timeout", {31'b0, bus.byte_ready_o}, 32'd1);
         bus.byte_valid_i = 1'b0;
         @(posedge clk); #1;
         return;
      end
      @(posedge clk); #1;
      last_acc_cyc = cyc;
      if (gap > 0) begin
         bus.byte_valid_i = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      send_byte(w[7:0],   gap);
      send_byte(w[15:8],  gap);
      send_byte(w[23:16], gap);
      send_byte(w[31:24], gap);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      bus.byte_valid_i = 1'b0;
      @(negedge clk);
      while ((bus.busy_o || bus.done_o) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("session_end_busy", {31'b0, bus.busy_o}, 32'd0);
      @(posedge clk); #1;
   endtask

   vec_t tbl[5];

   initial begin
      int mism;
      logic [7:0] i8;
      logic [31:0] exp_w;

      tbl[0] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 0, 32'hDEADBEEF, 32'h0000_0000};
      tbl[1] = '{8'h01, 8'h02, 8'h03, 8'h04, 1, 32'h04030201, 32'h0000_0004};
      tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 2, 32'hFFFFFFFF, 32'h0000_0008};
      tbl[3] = '{8'h00, 8'h00, 8'h00, 8'h80, 0, 32'h80000000, 32'h0000_000C};
      tbl[4] = '{8'h93, 8'h00, 8'h10, 8'h00, 3, 32'h00100093, 32'h0000_0010};

      rst_n            = 1'b0;
      bus.start_i      = 1'b0;
      bus.len_i        = 16'd0;
      bus.abort_i      = 1'b0;
      bus.byte_valid_i = 1'b0;
      bus.byte_data_i  = 8'h00;

      // Reset state
      #12;
      check("rst_byte_ready", {31'b0, bus.byte_ready_o}, 32'd0);
      check("rst_mem_we",     {31'b0, bus.mem_we_o},     32'd0);
      check("rst_mem_addr",   bus.mem_addr_o,            32'd0);
      check("rst_mem_data",   bus.mem_data_o,            32'd0);
      check("rst_busy",       {31'b0, bus.busy_o},       32'd0);
      check("rst_done",       {31'b0, bus.done_o},       32'd0);
      check("rst_err",        {31'b0, bus.err_o},        32'd0);
      check("rst_cpu_run",    {31'b0, bus.cpu_run_o},    32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic two-word load, no gaps
      clear_mon();
      start_load(16'd2, 1'b0);
      send_word(32'h00000013, 0);
      send_word(32'h00500293, 0);
      wait_idle();
      check("basic_nwr",     32'(wr_addr_q.size()), 32'd2);
      check("basic_addr0",   wr_addr(0), 32'h0);
      check("basic_data0",   wr_data(0), 32'h00000013);
      check("basic_addr1",   wr_addr(1), 32'h4);
      check("basic_data1",   wr_data(1), 32'h00500293);
      check("basic_latency", 32'((wr_cyc_q.size() > 1) ? wr_cyc_q[1] : -1), 32'(last_acc_cyc));
      check("basic_rate",    32'((wr_cyc_q.size() > 1) ? wr_cyc_q[1] - wr_cyc_q[0] : -1), 32'd5);
      check("basic_done_n",  32'(done_cnt), 32'd1);
      check("basic_done_t",  32'(done_cyc), 32'((wr_cyc_q.size() > 1) ? wr_cyc_q[1] + 1 : -9));
      check("basic_cpu_run", {31'b0, bus.cpu_run_o}, 32'd1);
      check("basic_err",     {31'b0, bus.err_o},     32'd0);

      // Same stream with 3-cycle gaps between bytes
      clear_mon();
      start_load(16'd2, 1'b0);
      send_word(32'h00000013, 3);
      send_word(32'h00500293, 3);
      wait_idle();
      check("gap_nwr",     32'(wr_addr_q.size()), 32'd2);
      check("gap_data0",   wr_data(0), 32'h00000013);
      check("gap_addr1",   wr_addr(1), 32'h4);
      check("gap_data1",   wr_data(1), 32'h00500293);
      check("gap_ready_in_write", 32'(overlap_cnt), 32'd0);
      check("gap_done_n",  32'(done_cnt), 32'd1);

      // Table-driven five-word load
      clear_mon();
      start_load(16'd5, 1'b0);
      for (int i = 0; i < 5; i++) begin
         send_byte(tbl[i].b0, tbl[i].gap);
         send_byte(tbl[i].b1, tbl[i].gap);
         send_byte(tbl[i].b2, tbl[i].gap);
         send_byte(tbl[i].b3, tbl[i].gap);
      end
      wait_idle();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("tbl%0d_addr", i), wr_addr(i), tbl[i].exp_addr);
         check($sformatf("tbl%0d_data", i), wr_data(i), tbl[i].exp_data);
      end
      check("tbl_nwr",    32'(wr_addr_q.size()), 32'd5);
      check("tbl_done_n", 32'(done_cnt), 32'd1);

      // len = 0: straight to DONE
      clear_mon();
      start_load(16'd0, 1'b0);
      wait_idle();
      check("len0_done_n",  32'(done_cnt), 32'd1);
      check("len0_done_t",  32'(done_cyc), 32'(start_cyc));
      check("len0_nwr",     32'(wr_addr_q.size()), 32'd0);
      check("len0_cpu_run", {31'b0, bus.cpu_run_o}, 32'd1);

      // len = 129: rejected
      clear_mon();
      start_load(16'd129, 1'b0);
      @(negedge clk);
      check("len129_err",     {31'b0, bus.err_o},     32'd1);
      check("len129_busy",    {31'b0, bus.busy_o},    32'd0);
      check("len129_cpu_run", {31'b0, bus.cpu_run_o}, 32'd1);
      repeat (3) @(negedge clk);
      check("len129_nwr",     32'(wr_addr_q.size()), 32'd0);
      @(posedge clk); #1;

      // len = 128: full memory
      clear_mon();
      start_load(16'd128, 1'b0);
      @(negedge clk);
      check("len128_err_clr", {31'b0, bus.err_o},     32'd0);
      check("len128_run_clr", {31'b0, bus.cpu_run_o}, 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 128; i++) begin
         i8 = 8'(i);
         send_word({8'h3C, ~i8, 8'hA5, i8}, 0);
      end
      wait_idle();
      mism = 0;
      for (int i = 0; i < 128; i++) begin
         i8    = 8'(i);
         exp_w = {8'h3C, ~i8, 8'hA5, i8};
         if (wr_data(i) !== exp_w || wr_addr(i) !== 32'(i * 4)) mism++;
      end
      check("len128_nwr",       32'(wr_addr_q.size()), 32'd128);
      check("len128_mismatches", 32'(mism), 32'd0);
      check("len128_last_addr", wr_addr(127), 32'h0000_01FC);
      check("len128_cpu_run",   {31'b0, bus.cpu_run_o}, 32'd1);

      // Abort during RECV of word 1
      clear_mon();
      start_load(16'd3, 1'b0);
      send_word(32'h11223344, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      bus.byte_valid_i = 1'b0;
      bus.abort_i      = 1'b1;
      @(posedge clk); #1;
      bus.abort_i      = 1'b0;
      @(negedge clk);
      check("abrt_busy",    {31'b0, bus.busy_o},    32'd0);
      check("abrt_err",     {31'b0, bus.err_o},     32'd1);
      check("abrt_cpu_run", {31'b0, bus.cpu_run_o}, 32'd0);
      repeat (3) @(negedge clk);
      check("abrt_nwr",     32'(wr_addr_q.size()), 32'd1);
      check("abrt_data0",   wr_data(0), 32'h11223344);
      check("abrt_done_n",  32'(done_cnt), 32'd0);
      @(posedge clk); #1;

      // New start (with abort also high) clears err and starts fresh
      clear_mon();
      start_load(16'd1, 1'b1);
      @(negedge clk);
      check("restart_busy", {31'b0, bus.busy_o}, 32'd1);
      check("restart_err",  {31'b0, bus.err_o},  32'd0);
      @(posedge clk); #1;
      send_word(32'hCAFEF00D, 0);
      wait_idle();
      check("restart_addr",    wr_addr(0), 32'h0);
      check("restart_data",    wr_data(0), 32'hCAFEF00D);
      check("restart_cpu_run", {31'b0, bus.cpu_run_o}, 32'd1);

      // Abort during the final WRITE
      clear_mon();
      start_load(16'd1, 1'b0);
      send_word(32'hDDCCBBAA, 0);
      bus.byte_valid_i = 1'b0;
      bus.abort_i      = 1'b1;
      @(posedge clk); #1;
      bus.abort_i      = 1'b0;
      wait_idle();
      repeat (2) @(posedge clk);
      #1;
      check("wabrt_nwr",     32'(wr_addr_q.size()), 32'd1);
      check("wabrt_data",    wr_data(0), 32'hDDCCBBAA);
      check("wabrt_done_n",  32'(done_cnt), 32'd0);
      check("wabrt_err",     {31'b0, bus.err_o},     32'd1);
      check("wabrt_cpu_run", {31'b0, bus.cpu_run_o}, 32'd0);

      // Asynchronous reset in the middle of word 1
      clear_mon();
      start_load(16'd2, 1'b0);
      send_word(32'h01020304, 0);
      send_byte(8'h77, 0);
      send_byte(8'h88, 0);
      rst_n = 1'b0;
      #1;
      check("mrst_byte_ready", {31'b0, bus.byte_ready_o}, 32'd0);
      check("mrst_busy",       {31'b0, bus.busy_o},       32'd0);
      check("mrst_mem_addr",   bus.mem_addr_o,            32'd0);
      check("mrst_mem_data",   bus.mem_data_o,            32'd0);
      check("mrst_err",        {31'b0, bus.err_o},        32'd0);
      check("mrst_cpu_run",    {31'b0, bus.cpu_run_o},    32'd0);
      bus.byte_valid_i = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      clear_mon();
      start_load(16'd1, 1'b0);
      send_word(32'h00001037, 1);
      wait_idle();
      check("post_rst_nwr",  32'(wr_addr_q.size()), 32'd1);
      check("post_rst_addr", wr_addr(0), 32'h0);
      check("post_rst_data", wr_data(0), 32'h00001037);
      check("post_rst_done", 32'(done_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
